// File: rtl/i2c_slave_core.sv
// i2c_slave_core: I2C target with fixed address and auto-increment pointer.
// Bridges bus writes/reads to a byte-wide register port; open-drain SDA.
module i2c_slave_core #(
    parameter logic [6:0]  SLAVE_ADDR = 7'h42,
    parameter int unsigned AW         = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          scl_i,
    input  logic          sda_i,
    output logic          sda_o,
    output logic          wr_en,
    output logic [AW-1:0] wr_addr,
    output logic [7:0]    wr_data,
    output logic [AW-1:0] rd_addr,
    input  logic [7:0]    rd_data,
    output logic          busy,
    output logic          xfer_done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_ADDR_ACK,
        S_WR_BYTE,
        S_WR_ACK,
        S_RD_BYTE,
        S_RD_ACK,
        S_IGNORE
    } state_t;

    logic          scl_s1_q, scl_s2_q, scl_h_q;
    logic          sda_s1_q, sda_s2_q, sda_h_q;
    logic [1:0]    arm_q;
    logic          armed;
    logic          rise_q, fall_q, start_q, stop_q;

    state_t        state_q, state_d;
    logic [2:0]    bitcnt_q, bitcnt_d;
    logic [7:0]    sh_q, sh_d;
    logic [AW-1:0] ptr_q, ptr_d;
    logic          sda_q, sda_d;
    logic          busy_q, busy_d;
    logic          first_q, first_d;
    logic          wr_en_q, wr_en_d;
    logic [AW-1:0] wr_addr_q, wr_addr_d;
    logic [7:0]    wr_data_q, wr_data_d;
    logic          done_q, done_d;
    logic [7:0]    byte_c;

    // Edges are suppressed until the history flops hold real pin values,
    // so the reset value of the synchronizer cannot fake a START.
    assign armed  = (arm_q == 2'd3);
    assign byte_c = {sh_q[6:0], sda_s2_q};

    // Synchronize pins and register SCL edges plus START/STOP conditions.
    always_ff @(posedge clk) begin
        if (rst) begin
            scl_s1_q <= 1'b1;
            scl_s2_q <= 1'b1;
            scl_h_q  <= 1'b1;
            sda_s1_q <= 1'b1;
            sda_s2_q <= 1'b1;
            sda_h_q  <= 1'b1;
            arm_q    <= 2'd0;
            rise_q   <= 1'b0;
            fall_q   <= 1'b0;
            start_q  <= 1'b0;
            stop_q   <= 1'b0;
        end else begin
            scl_s1_q <= scl_i;
            scl_s2_q <= scl_s1_q;
            scl_h_q  <= scl_s2_q;
            sda_s1_q <= sda_i;
            sda_s2_q <= sda_s1_q;
            sda_h_q  <= sda_s2_q;
            if (!armed) begin
                arm_q <= arm_q + 2'd1;
            end
            rise_q  <= armed & scl_s2_q & ~scl_h_q;
            fall_q  <= armed & ~scl_s2_q & scl_h_q;
            start_q <= armed & scl_s2_q & scl_h_q
                       & ~sda_s2_q & sda_h_q;
            stop_q  <= armed & scl_s2_q & sda_s2_q & ~sda_h_q;
        end
    end

    // Protocol state and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            bitcnt_q  <= 3'd0;
            sh_q      <= 8'd0;
            ptr_q     <= '0;
            sda_q     <= 1'b1;
            busy_q    <= 1'b0;
            first_q   <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= 8'd0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            bitcnt_q  <= bitcnt_d;
            sh_q      <= sh_d;
            ptr_q     <= ptr_d;
            sda_q     <= sda_d;
            busy_q    <= busy_d;
            first_q   <= first_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            done_q    <= done_d;
        end
    end

    // Next-state logic; bus conditions override any SCL edge.
    always_comb begin
        state_d   = state_q;
        bitcnt_d  = bitcnt_q;
        sh_d      = sh_q;
        ptr_d     = ptr_q;
        sda_d     = sda_q;
        busy_d    = busy_q;
        first_d   = first_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        done_d    = 1'b0;
        if (start_q) begin
            state_d  = S_ADDR;
            bitcnt_d = 3'd0;
            sda_d    = 1'b1;
            busy_d   = 1'b0;
        end else if (stop_q) begin
            state_d  = S_IDLE;
            bitcnt_d = 3'd0;
            sda_d    = 1'b1;
            busy_d   = 1'b0;
            done_d   = busy_q;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                end
                S_ADDR: begin
                    if (rise_q) begin
                        sh_d     = byte_c;
                        bitcnt_d = bitcnt_q + 3'd1;
                        if (bitcnt_q == 3'd7) begin
                            bitcnt_d = 3'd0;
                            if (byte_c[7:1] == SLAVE_ADDR &&
                                byte_c[7:1] != 7'd0) begin
                                state_d = S_ADDR_ACK;
                                busy_d  = 1'b1;
                            end else begin
                                state_d = S_IGNORE;
                            end
                        end
                    end
                end
                S_ADDR_ACK: begin
                    if (fall_q) begin
                        if (bitcnt_q == 3'd0) begin
                            sda_d    = 1'b0;
                            bitcnt_d = 3'd1;
                        end else if (sh_q[0]) begin
                            bitcnt_d = 3'd0;
                            sh_d     = rd_data;
                            sda_d    = rd_data[7];
                            ptr_d    = ptr_q + 1'b1;
                            state_d  = S_RD_BYTE;
                        end else begin
                            bitcnt_d = 3'd0;
                            sda_d    = 1'b1;
                            first_d  = 1'b1;
                            state_d  = S_WR_BYTE;
                        end
                    end
                end
                S_WR_BYTE: begin
                    if (rise_q) begin
                        sh_d     = byte_c;
                        bitcnt_d = bitcnt_q + 3'd1;
                        if (bitcnt_q == 3'd7) begin
                            bitcnt_d = 3'd0;
                            state_d  = S_WR_ACK;
                            if (first_q) begin
                                ptr_d   = byte_c[AW-1:0];
                                first_d = 1'b0;
                            end else begin
                                wr_en_d   = 1'b1;
                                wr_addr_d = ptr_q;
                                wr_data_d = byte_c;
                                ptr_d     = ptr_q + 1'b1;
                            end
                        end
                    end
                end
                S_WR_ACK: begin
                    if (fall_q) begin
                        if (bitcnt_q == 3'd0) begin
                            sda_d    = 1'b0;
                            bitcnt_d = 3'd1;
                        end else begin
                            sda_d    = 1'b1;
                            bitcnt_d = 3'd0;
                            state_d  = S_WR_BYTE;
                        end
                    end
                end
                S_RD_BYTE: begin
                    if (fall_q) begin
                        if (bitcnt_q == 3'd7) begin
                            sda_d    = 1'b1;
                            bitcnt_d = 3'd0;
                            state_d  = S_RD_ACK;
                        end else begin
                            sda_d    = sh_q[6];
                            sh_d     = {sh_q[6:0], 1'b0};
                            bitcnt_d = bitcnt_q + 3'd1;
                        end
                    end
                end
                S_RD_ACK: begin
                    if (rise_q && sda_s2_q) begin
                        sda_d   = 1'b1;
                        busy_d  = 1'b0;
                        state_d = S_IGNORE;
                    end else if (fall_q) begin
                        sh_d    = rd_data;
                        sda_d   = rd_data[7];
                        ptr_d   = ptr_q + 1'b1;
                        state_d = S_RD_BYTE;
                    end
                end
                S_IGNORE: begin
                    sda_d = 1'b1;
                end
            endcase
        end
    end

    assign sda_o     = sda_q;
    assign wr_en     = wr_en_q;
    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;
    assign rd_addr   = ptr_q;
    assign busy      = busy_q;
    assign xfer_done = done_q;

endmodule

// File: tb/tb_i2c_slave_core.sv
// tb_i2c_slave_core: bus master model driving i2c_slave_core, with
// scoreboard queues checked by monitors on frames, writes and STOPs.
module tb_i2c_slave_core;

    localparam int H = 8;

    typedef struct packed {
        logic [7:0] b;
        logic       ack;
    } frame_t;

    typedef struct packed {
        logic [3:0] a;
        logic [7:0] d;
    } wr_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       m_scl, m_sda;
    logic       sda_bus;
    logic       sda_o, wr_en, busy, xfer_done;
    logic [3:0] wr_addr, rd_addr;
    logic [7:0] wr_data, rd_data;

    frame_t exp_fr[$];
    wr_t    exp_wr[$];
    int     exp_done = 0;
    int     n_vec = 0;
    int     n_err = 0;

    logic quiet = 1'b0;
    logic sda_low_seen = 1'b0;
    logic busy_seen = 1'b0;

    assign sda_bus = m_sda & sda_o;
    assign rd_data = 8'(rd_addr) * 8'h11;

    always #5 clk = ~clk;

    i2c_slave_core #(.SLAVE_ADDR(7'h42), .AW(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .scl_i     (m_scl),
        .sda_i     (sda_bus),
        .sda_o     (sda_o),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .busy      (busy),
        .xfer_done (xfer_done)
    );

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic t_bit(input logic b);
        m_sda = b;
        cyc(H);
        m_scl = 1'b1;
        cyc(H);
        m_scl = 1'b0;
        cyc(4);
    endtask

    task automatic t_start;
        m_sda = 1'b1;
        cyc(H);
        m_scl = 1'b1;
        cyc(H);
        m_sda = 1'b0;
        cyc(H);
        m_scl = 1'b0;
        cyc(4);
    endtask

    task automatic t_stop;
        m_sda = 1'b0;
        cyc(H);
        m_scl = 1'b1;
        cyc(H);
        m_sda = 1'b1;
        cyc(H);
    endtask

    task automatic t_wframe(input logic [7:0] b, input logic ack);
        exp_fr.push_back('{b: b, ack: ack});
        for (int i = 7; i >= 0; i--) t_bit(b[i]);
        t_bit(1'b1);
    endtask

    task automatic t_rframe(input logic [7:0] b, input logic mack);
        exp_fr.push_back('{b: b, ack: mack});
        for (int i = 0; i < 8; i++) t_bit(1'b1);
        t_bit(mack);
    endtask

    task automatic push_wr(input logic [3:0] a, input logic [7:0] d);
        exp_wr.push_back('{a: a, d: d});
    endtask

    // Bus monitor: assembles 9-bit frames between START/STOP.
    logic       p_scl = 1'b1;
    logic       p_sda = 1'b1;
    logic [8:0] fsh = '0;
    int         fcnt = 0;
    always @(negedge clk) begin
        frame_t f;
        if (p_scl && m_scl && p_sda && !sda_bus) begin
            fcnt = 0;
        end else if (p_scl && m_scl && !p_sda && sda_bus) begin
            fcnt = 0;
        end else if (!p_scl && m_scl) begin
            fsh = {fsh[7:0], sda_bus};
            fcnt++;
            if (fcnt == 9) begin
                fcnt = 0;
                if (exp_fr.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL frame: got %0h expected none", fsh);
                end else begin
                    f = exp_fr.pop_front();
                    chk("frame", 32'(fsh), 32'({f.b, f.ack}));
                end
            end
        end
        p_scl = m_scl;
        p_sda = sda_bus;
    end

    // Register-port and completion monitor.
    always @(negedge clk) begin
        wr_t w;
        if (quiet && !sda_o) sda_low_seen = 1'b1;
        if (quiet && busy) busy_seen = 1'b1;
        if (wr_en) begin
            if (exp_wr.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL wr_en: got %0h/%0h expected none",
                         wr_addr, wr_data);
            end else begin
                w = exp_wr.pop_front();
                chk("wr_port", {20'd0, wr_addr, wr_data},
                    {20'd0, w.a, w.d});
            end
        end
        if (xfer_done) begin
            n_vec++;
            if (exp_done == 0) begin
                n_err++;
                $display("FAIL xfer_done: got pulse expected none");
            end else begin
                exp_done--;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst   = 1'b1;
        m_scl = 1'b1;
        m_sda = 1'b1;
        cyc(4);
        @(negedge clk);
        chk("rst_sda_o", 32'(sda_o), 1);
        chk("rst_wr_en", 32'(wr_en), 0);
        chk("rst_wr_addr", 32'(wr_addr), 0);
        chk("rst_wr_data", 32'(wr_data), 0);
        chk("rst_rd_addr", 32'(rd_addr), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(xfer_done), 0);
        cyc(1);
        rst = 1'b0;
        cyc(4);

        // pointer then two data bytes
        t_start;
        t_wframe(8'h84, 1'b0);
        @(negedge clk);
        chk("busy_match", 32'(busy), 1);
        t_wframe(8'h03, 1'b0);
        push_wr(4'd3, 8'hA5);
        t_wframe(8'hA5, 1'b0);
        push_wr(4'd4, 8'h5A);
        t_wframe(8'h5A, 1'b0);
        exp_done++;
        t_stop;
        cyc(4);
        chk("wr_rd_addr", 32'(rd_addr), 5);
        chk("wr_busy_end", 32'(busy), 0);

        // address mismatch
        sda_low_seen = 1'b0;
        busy_seen    = 1'b0;
        quiet        = 1'b1;
        t_start;
        t_wframe(8'h86, 1'b1);
        t_wframe(8'h11, 1'b1);
        t_stop;
        cyc(4);
        quiet = 1'b0;
        chk("nm_sda_low", 32'(sda_low_seen), 0);
        chk("nm_busy", 32'(busy_seen), 0);
        chk("nm_rd_addr", 32'(rd_addr), 5);

        // read with wrap
        t_start;
        t_wframe(8'h84, 1'b0);
        t_wframe(8'h0E, 1'b0);
        t_start;
        t_wframe(8'h85, 1'b0);
        t_rframe(8'hEE, 1'b0);
        t_rframe(8'hFF, 1'b0);
        t_rframe(8'h00, 1'b1);
        @(negedge clk);
        chk("rd_nack_sda", 32'(sda_o), 1);
        chk("rd_nack_busy", 32'(busy), 0);
        t_stop;
        cyc(4);
        chk("rd_rd_addr", 32'(rd_addr), 1);

        // write wrap
        t_start;
        t_wframe(8'h84, 1'b0);
        t_wframe(8'h0F, 1'b0);
        push_wr(4'd15, 8'h01);
        t_wframe(8'h01, 1'b0);
        push_wr(4'd0, 8'h02);
        t_wframe(8'h02, 1'b0);
        exp_done++;
        t_stop;
        cyc(4);
        chk("ww_rd_addr", 32'(rd_addr), 1);

        // reset during bit 4 of read byte 0x22
        t_start;
        t_wframe(8'h84, 1'b0);
        t_wframe(8'h02, 1'b0);
        t_start;
        t_wframe(8'h85, 1'b0);
        exp_fr.push_back('{b: 8'h3F, ack: 1'b1});
        t_bit(1'b1);
        t_bit(1'b1);
        t_bit(1'b1);
        m_sda = 1'b1;
        cyc(H);
        chk("mr_bit4_drv", 32'(sda_o), 0);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("mr_sda_rel", 32'(sda_o), 1);
        cyc(1);
        rst          = 1'b0;
        sda_low_seen = 1'b0;
        busy_seen    = 1'b0;
        quiet        = 1'b1;
        m_scl = 1'b1;
        cyc(H);
        m_scl = 1'b0;
        cyc(4);
        for (int i = 0; i < 4; i++) t_bit(1'b1);
        t_bit(1'b1);
        t_stop;
        cyc(4);
        quiet = 1'b0;
        chk("mr_sda_low", 32'(sda_low_seen), 0);
        chk("mr_busy", 32'(busy_seen), 0);
        chk("mr_rd_addr", 32'(rd_addr), 0);
        t_start;
        t_wframe(8'h84, 1'b0);
        t_wframe(8'h07, 1'b0);
        push_wr(4'd7, 8'h3C);
        t_wframe(8'h3C, 1'b0);
        exp_done++;
        t_stop;
        cyc(4);

        // repeated START during bit 3 of a data byte
        t_start;
        t_wframe(8'h84, 1'b0);
        t_wframe(8'h08, 1'b0);
        t_bit(1'b1);
        t_bit(1'b0);
        t_bit(1'b1);
        t_start;
        t_wframe(8'h84, 1'b0);
        t_wframe(8'h09, 1'b0);
        push_wr(4'd9, 8'h77);
        t_wframe(8'h77, 1'b0);
        exp_done++;
        t_stop;
        cyc(8);
        chk("rs_rd_addr", 32'(rd_addr), 10);

        chk("left_frames", 32'(exp_fr.size()), 0);
        chk("left_writes", 32'(exp_wr.size()), 0);
        chk("left_done", 32'(exp_done), 0);
        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_err);
        $finish;
    end

endmodule
